move_entry: RTL and testbench
=============================

# move_entry

Player move-entry front end for the tic-tac-toe datapath. It synchronises and debounces the raw move push-button, then validates the selected cell against the current board and the game-running flag. It issues one single-cycle move strobe carrying the cell index and the mover's 2-bit mark, which downstream display and board logic latch. It alternates players on every accepted move and flags rejected attempts.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised-stable cycles required to accept a press or a release; legal range 1..255.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- btn_raw  input  1  raw push-button, asynchronous to clk, may bounce.
- cell_sel  input  4  selected cell index; 0..8 are legal.
- gend  input  1  game-running flag: 1 = game still running, 0 = game ended (win or draw).
- board  input  18  current board, 2 bits per cell; cell n at bits [2n+1:2n]; 00 = empty.
- move_valid  output  1  one-cycle strobe for an accepted move.
- move_cell  output  4  cell index of the last accepted move; holds between strobes.
- move_mark  output  2  mark of the last accepted move (01 = X, 10 = O); holds between strobes.
- cur_player  output  1  player to move next (0 = X, 1 = O).
- reject  output  1  one-cycle strobe for a refused attempt.

## Operation
- btn_raw passes through a 2-flop synchroniser (btn_s). Debouncing and all decisions use btn_s only.
- FSM states:
  - IDLE: wait for btn_s=1.
  - DEBOUNCE: count consecutive btn_s=1 cycles. btn_s=0 clears the counter and returns to IDLE. Reaching DEBOUNCE_CYCLES moves to CHECK.
  - CHECK: single cycle. Sample cell_sel, board and gend, then decide. Always moves to RELEASE.
  - RELEASE: count consecutive btn_s=0 cycles. btn_s=1 clears the counter. Reaching DEBOUNCE_CYCLES moves to IDLE.
- CHECK accepts the attempt only if all of the following hold:
  - gend=1;
  - cell_sel<=8;
  - the selected cell's board field is 00 (see Configuration).
- On accept, in the cycle after CHECK:
  - move_valid=1;
  - move_cell=cell_sel;
  - move_mark=01 if cur_player=0, otherwise 10;
  - cur_player toggles on the same edge.
- On refuse, in the cycle after CHECK: reject=1. move_cell, move_mark and cur_player are unchanged.
- move_valid and reject are mutually exclusive and never high for two consecutive cycles.
- Exactly one move_valid or reject per debounced press, however long the button is held.
- Debounce counter width is 8 bits. It saturates; it never wraps.

## Timing
- Reset values:
  - move_valid=0, reject=0;
  - move_cell=0, move_mark=00, cur_player=0;
  - synchroniser flops 0, counter 0.
- Reset sends the FSM to RELEASE, not IDLE. A button held through reset produces no move until it has been released for DEBOUNCE_CYCLES cycles and pressed again.
- Reset asserted mid-debounce or in CHECK cancels the attempt: no strobe is produced.
- Latency: with btn_raw held high from edge 0 (the first edge that samples it high), the strobe is high during the cycle after edge DEBOUNCE_CYCLES+2. That is DEBOUNCE_CYCLES+3 edges counted from edge 0.
- board and cell_sel are sampled only at the CHECK edge. Changes at other times have no effect.
- gend falling during DEBOUNCE or RELEASE has no effect until the next CHECK.
- Glitch rejection: a btn_s high pulse shorter than DEBOUNCE_CYCLES yields no strobe.

## Configuration
- MOVE_ENTRY_OCC_CHECK_EN defined: the occupancy test is applied. A non-00 board field for the selected cell forces reject.
- MOVE_ENTRY_OCC_CHECK_EN undefined: board is ignored. Acceptance depends only on gend and the cell_sel range, and an occupied cell is accepted. This build is for setups where the board logic performs its own occupancy check.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and MOVE_ENTRY_OCC_CHECK_EN defined unless stated.
- Reset, release, then press held with cell_sel=4, board=0, gend=1 -> move_valid pulses once, 7 edges after the first sample; move_cell=4, move_mark=01, cur_player becomes 1. A second press with cell_sel=0 -> move_mark=10, cur_player becomes 0.
- btn_raw high for 3 cycles, then low -> no move_valid, no reject, FSM back in IDLE. 10-cycle bounce train followed by a steady press -> exactly one strobe.
- Press with cell_sel=2 and board[5:4]=01 -> reject pulses once, cur_player unchanged. Same stimulus with the macro undefined -> move_valid with move_cell=2.
- Press with cell_sel=9, and separately press with gend=0 and a legal empty cell -> reject each time, no move_valid.
- btn_raw held high across reset -> no strobe. Release for 4 cycles, then press -> one move_valid with move_mark=01.
- Reset asserted during DEBOUNCE -> no strobe, all outputs at reset values; button held 100 cycles after a press -> still exactly one strobe.

Source files
------------

// File: rtl/move_entry.sv
// move_entry: debounced move push-button front end for tic-tac-toe.
// Validates the selected cell and issues one move or reject strobe per press.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable btn_s cycles needed for a press or a release (1..255)
// Build option:
//   MOVE_ENTRY_OCC_CHECK_EN  when defined, an occupied cell is refused
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   btn_raw      raw asynchronous push-button
//   cell_sel     selected cell 0..8
//   gend         1 = game still running
//   board        2 bits per cell, cell n at [2n+1:2n], 00 = empty
//   move_valid   one-cycle accepted-move strobe
//   move_cell    cell of last accepted move
//   move_mark    mark of last accepted move (01 = X, 10 = O)
//   cur_player   player to move next (0 = X, 1 = O)
//   reject       one-cycle refused-attempt strobe
module move_entry #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_raw,
    input  logic [3:0]  cell_sel,
    input  logic        gend,
    input  logic [17:0] board,
    output logic        move_valid,
    output logic [3:0]  move_cell,
    output logic [1:0]  move_mark,
    output logic        cur_player,
    output logic        reject
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_CHECK,
        S_RELEASE
    } state_t;

    localparam logic [7:0] LP_DB = 8'(DEBOUNCE_CYCLES);

    state_t      r_state;
    logic [1:0]  r_sync;
    logic [7:0]  r_cnt;
    logic        r_move_valid;
    logic        r_reject;
    logic [3:0]  r_move_cell;
    logic [1:0]  r_move_mark;
    logic        r_cur_player;

    logic        w_btn_s;
    logic [7:0]  w_cnt_inc;
    logic        w_cnt_done;
    logic        w_range_ok;
    logic        w_occ_ok;
    logic        w_accept;

    assign w_btn_s = r_sync[1];

    // Saturating increment; reaching the threshold counts this cycle.
    assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign w_cnt_done = (w_cnt_inc >= LP_DB);

    assign w_range_ok = (cell_sel <= 4'd8);

`ifdef MOVE_ENTRY_OCC_CHECK_EN
    logic [1:0] w_field;

    always_comb begin
        w_field = 2'b00;
        for (int i = 0; i < 9; i++) begin
            if (cell_sel == 4'(i)) begin
                w_field = board[2*i +: 2];
            end
        end
    end

    assign w_occ_ok = (w_field == 2'b00);
`else
    // Board logic downstream owns the occupancy check in this build.
    logic w_unused_board;
    assign w_unused_board = ^board;
    assign w_occ_ok       = 1'b1;
`endif

    assign w_accept = gend && w_range_ok && w_occ_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync       <= 2'b00;
            r_cnt        <= 8'd0;
            // Start in RELEASE so a button held through reset is ignored.
            r_state      <= S_RELEASE;
            r_move_valid <= 1'b0;
            r_reject     <= 1'b0;
            r_move_cell  <= 4'd0;
            r_move_mark  <= 2'b00;
            r_cur_player <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], btn_raw};
            r_move_valid <= 1'b0;
            r_reject     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_btn_s) begin
                        if (w_cnt_done) begin
                            r_cnt   <= 8'd0;
                            r_state <= S_CHECK;
                        end else begin
                            r_cnt   <= w_cnt_inc;
                            r_state <= S_DEBOUNCE;
                        end
                    end else begin
                        r_cnt <= 8'd0;
                    end
                end
                S_DEBOUNCE: begin
                    if (!w_btn_s) begin
                        r_cnt   <= 8'd0;
                        r_state <= S_IDLE;
                    end else if (w_cnt_done) begin
                        r_cnt   <= 8'd0;
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        r_move_valid <= 1'b1;
                        r_move_cell  <= cell_sel;
                        r_move_mark  <= r_cur_player ? 2'b10 : 2'b01;
                        r_cur_player <= ~r_cur_player;
                    end else begin
                        r_reject <= 1'b1;
                    end
                    r_cnt   <= 8'd0;
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (w_btn_s) begin
                        r_cnt <= 8'd0;
                    end else if (w_cnt_done) begin
                        r_cnt   <= 8'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_cnt   <= 8'd0;
                    r_state <= S_RELEASE;
                end
            endcase
        end
    end

    assign move_valid = r_move_valid;
    assign reject     = r_reject;
    assign move_cell  = r_move_cell;
    assign move_mark  = r_move_mark;
    assign cur_player = r_cur_player;

endmodule

// File: tb/tb_move_entry.sv
// tb_move_entry: directed bench for move_entry (DEBOUNCE_CYCLES = 4).
// Expected strobes are queued as attempts are made and matched as they appear.
module tb_move_entry;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_raw = 1'b0;
    logic [3:0]  cell_sel = 4'd0;
    logic        gend = 1'b1;
    logic [17:0] board = 18'd0;
    logic        move_valid;
    logic [3:0]  move_cell;
    logic [1:0]  move_mark;
    logic        cur_player;
    logic        reject;

    int n_checks = 0;
    int n_fails  = 0;

    // {move_valid, reject, move_cell, move_mark, cur_player}
    logic [8:0] sb[$];
    logic [3:0] m_cell;
    logic [1:0] m_mark;
    logic       m_player;
    logic       prev_strobe = 1'b0;

    move_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .cell_sel   (cell_sel),
        .gend       (gend),
        .board      (board),
        .move_valid (move_valid),
        .move_cell  (move_cell),
        .move_mark  (move_mark),
        .cur_player (cur_player),
        .reject     (reject)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (observed timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (move_valid || reject) begin
            n_checks++;
            assert (!(move_valid && reject)) else begin
                n_fails++;
                $error("FAIL both_strobes: observed 1 expected 0");
            end
            n_checks++;
            assert (!prev_strobe) else begin
                n_fails++;
                $error("FAIL back_to_back: observed 1 expected 0");
            end
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fails++;
                $error("FAIL unexpected_strobe: observed %b%b expected none",
                       move_valid, reject);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++;
                assert ({move_valid, reject, move_cell, move_mark, cur_player} === e)
                else begin
                    n_fails++;
                    $error("FAIL strobe: observed %b expected %b",
                           {move_valid, reject, move_cell, move_mark, cur_player}, e);
                end
            end
        end
        prev_strobe = move_valid || reject;
    end

    task automatic model_reset();
        m_cell   = 4'd0;
        m_mark   = 2'b00;
        m_player = 1'b0;
    endtask

    task automatic model_attempt();
        logic ok;
        logic [17:0] sh;
        sh = board >> (2 * int'(cell_sel));
        ok = gend && (cell_sel <= 4'd8);
`ifdef MOVE_ENTRY_OCC_CHECK_EN
        ok = ok && (sh[1:0] == 2'b00);
`endif
        if (ok) begin
            m_cell   = cell_sel;
            m_mark   = m_player ? 2'b10 : 2'b01;
            m_player = ~m_player;
            sb.push_back({1'b1, 1'b0, m_cell, m_mark, m_player});
        end else begin
            sb.push_back({1'b0, 1'b1, m_cell, m_mark, m_player});
        end
    endtask

    task automatic do_reset(input int cyc);
        reset = 1'b1;
        repeat (cyc) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic attempt(input logic [3:0] c, input logic [17:0] b,
                           input logic g, input int hold);
        cell_sel = c;
        board    = b;
        gend     = g;
        model_attempt();
        btn_raw = 1'b1;
        repeat (hold) @(negedge clk);
        btn_raw = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset(2);
        chk("rst_valid", move_valid, 0);
        chk("rst_reject", reject, 0);
        chk("rst_cell", move_cell, 0);
        chk("rst_mark", move_mark, 0);
        chk("rst_player", cur_player, 0);
        repeat (8) @(negedge clk);

        // First move: latency of 7 edges from the first sample
        cell_sel = 4'd4;
        board    = 18'd0;
        gend     = 1'b1;
        model_attempt();
        btn_raw = 1'b1;
        repeat (6) @(negedge clk);
        chk("lat_early", move_valid, 0);
        @(negedge clk);
        chk("lat_on", move_valid, 1);
        repeat (5) @(negedge clk);
        btn_raw = 1'b0;
        repeat (10) @(negedge clk);
        chk("player_after_x", cur_player, 1);

        attempt(4'd0, 18'h00200, 1'b1, 12);
        chk("player_after_o", cur_player, 0);

        // Short pulse
        btn_raw = 1'b1;
        repeat (3) @(negedge clk);
        btn_raw = 1'b0;
        repeat (10) @(negedge clk);

        // Bounce train, then steady press
        cell_sel = 4'd1;
        board    = 18'h00202;
        for (int i = 0; i < 10; i++) begin
            btn_raw = ~btn_raw;
            @(negedge clk);
        end
        attempt(4'd1, 18'h00202, 1'b1, 12);

        // Occupied cell 2
        attempt(4'd2, 18'h00010, 1'b1, 12);
        // Out-of-range cell and ended game
        attempt(4'd9, 18'd0, 1'b1, 12);
        attempt(4'd5, 18'd0, 1'b0, 12);
        chk("player_after_rej", cur_player, m_player);

        // Button held through reset
        btn_raw = 1'b1;
        do_reset(3);
        repeat (20) @(negedge clk);
        chk("held_rst_player", cur_player, 0);
        btn_raw = 1'b0;
        repeat (6) @(negedge clk);
        attempt(4'd7, 18'd0, 1'b1, 12);
        chk("held_rst_mark", move_mark, 2'b01);

        // Reset during debounce
        cell_sel = 4'd3;
        btn_raw  = 1'b1;
        repeat (3) @(negedge clk);
        btn_raw = 1'b0;
        do_reset(2);
        chk("mid_rst_cell", move_cell, 0);
        chk("mid_rst_mark", move_mark, 0);
        chk("mid_rst_player", cur_player, 0);
        chk("mid_rst_valid", move_valid, 0);
        repeat (8) @(negedge clk);

        // Long hold; inputs change after the strobe and must be ignored
        cell_sel = 4'd8;
        board    = 18'd0;
        model_attempt();
        btn_raw = 1'b1;
        repeat (20) @(negedge clk);
        cell_sel = 4'd6;
        board    = 18'h3FFFF;
        repeat (80) @(negedge clk);
        btn_raw = 1'b0;
        repeat (12) @(negedge clk);
        chk("hold_cell", move_cell, 8);
        chk("hold_player", cur_player, 1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
